issue_instr_queue: RTL and testbench

- FIFO between the decoder and the issue stage; producer side of the decoded-instruction valid/ack handshake consumed by the scoreboard.
- Buffers decoded scoreboard entries with their original 32-bit encodings and control-flow flags.
- Presents the oldest entry with valid held until ack.
- Throttles issue of control-flow instructions when too many are unresolved; clears on flush.

---
 rtl/issue_instr_queue.sv | 120 ++++++++++++
 tb/tb_issue_instr_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/issue_instr_queue.sv
// Decoded-instruction queue between decoder and issue stage.
// Holds the oldest entry for the scoreboard and throttles issue of unresolved control flow.
module issue_instr_queue #(
    parameter int unsigned CVA6Cfg        = 32'd0,
    parameter type         scoreboard_entry_t = logic,
    parameter int unsigned DEPTH          = 32'd4,
    parameter int unsigned MAX_CF_PENDING = 32'd1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                flush_i,
    input  scoreboard_entry_t                   instr_i,
    input  logic [31:0]                         orig_instr_i,
    input  logic                                is_ctrl_flow_i,
    input  logic                                instr_valid_i,
    output logic                                instr_ready_o,
    output scoreboard_entry_t                   decoded_instr_o,
    output logic [31:0]                         orig_instr_o,
    output logic                                is_ctrl_flow_o,
    output logic                                decoded_instr_valid_o,
    input  logic                                decoded_instr_ack_i,
    input  logic                                resolve_branch_i,
    output logic [$clog2(DEPTH):0]              count_o,
    output logic [$clog2(MAX_CF_PENDING):0]     cf_pending_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CF_W  = $clog2(MAX_CF_PENDING) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CF_W-1:0]  CF_MAX_C = CF_W'(MAX_CF_PENDING);

    scoreboard_entry_t instr_mem_r [DEPTH];
    logic [31:0]       orig_mem_r  [DEPTH];
    logic [DEPTH-1:0]  cf_mem_r;

    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CF_W-1:0]  cf_pending_r;

    logic             head_present_s;
    logic             head_cf_s;
    logic             push_s;
    logic             pop_s;
    logic             cf_inc_s;
    logic             cf_dec_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic [CF_W-1:0]  cf_nxt_s;

    // Head presentation, issue gating and handshake qualification.
    always_comb begin
        head_present_s        = (count_r != {CNT_W{1'b0}});
        head_cf_s             = head_present_s & cf_mem_r[rd_ptr_r];
        instr_ready_o         = (count_r < DEPTH_C);
        is_ctrl_flow_o        = head_cf_s;
        decoded_instr_valid_o = head_present_s && !(head_cf_s && (cf_pending_r == CF_MAX_C)) && !flush_i;
        push_s                = instr_valid_i && instr_ready_o && !flush_i;
        pop_s                 = decoded_instr_valid_o && decoded_instr_ack_i;
        cf_inc_s              = pop_s && head_cf_s;
        cf_dec_s              = resolve_branch_i && (cf_pending_r != {CF_W{1'b0}});
        count_o               = count_r;
        cf_pending_o          = cf_pending_r;
        if (head_present_s) begin
            decoded_instr_o = instr_mem_r[rd_ptr_r];
            orig_instr_o    = orig_mem_r[rd_ptr_r];
        end else begin
            decoded_instr_o = '0;
            orig_instr_o    = 32'd0;
        end
    end

    // Next occupancy and pending control-flow count; resolve at zero saturates.
    always_comb begin
        count_nxt_s = count_r;
        cf_nxt_s    = cf_pending_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
        if (cf_inc_s && !cf_dec_s) begin
            cf_nxt_s = cf_pending_r + CF_W'(1);
        end else if (!cf_inc_s && cf_dec_s) begin
            cf_nxt_s = cf_pending_r - CF_W'(1);
        end else begin
            cf_nxt_s = cf_pending_r;
        end
    end

    // Pointer, occupancy and pending-branch state; flush clears synchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_r     <= {PTR_W{1'b0}};
            wr_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            cf_pending_r <= {CF_W{1'b0}};
        end else if (flush_i) begin
            rd_ptr_r     <= {PTR_W{1'b0}};
            wr_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            cf_pending_r <= {CF_W{1'b0}};
        end else begin
            rd_ptr_r     <= pop_s  ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
            wr_ptr_r     <= push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
            count_r      <= count_nxt_s;
            cf_pending_r <= cf_nxt_s;
        end
    end

    // Entry storage; contents are only observed while counted as occupied.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            instr_mem_r[wr_ptr_r] <= instr_i;
            orig_mem_r[wr_ptr_r]  <= orig_instr_i;
            cf_mem_r[wr_ptr_r]    <= is_ctrl_flow_i;
        end
    end

endmodule

// File: tb/tb_issue_instr_queue.sv
// Directed self-checking bench for issue_instr_queue (DEPTH=4, MAX_CF_PENDING=1).
module tb_issue_instr_queue;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic [7:0]  instr_i;
    logic [31:0] orig_instr_i;
    logic        is_ctrl_flow_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [7:0]  decoded_instr_o;
    logic [31:0] orig_instr_o;
    logic        is_ctrl_flow_o;
    logic        decoded_instr_valid_o;
    logic        decoded_instr_ack_i;
    logic        resolve_branch_i;
    logic [2:0]  count_o;
    logic [0:0]  cf_pending_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    issue_instr_queue #(
        .CVA6Cfg           (32'd0),
        .scoreboard_entry_t(logic [7:0]),
        .DEPTH             (32'd4),
        .MAX_CF_PENDING    (32'd1)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_ni),
        .flush_i              (flush_i),
        .instr_i              (instr_i),
        .orig_instr_i         (orig_instr_i),
        .is_ctrl_flow_i       (is_ctrl_flow_i),
        .instr_valid_i        (instr_valid_i),
        .instr_ready_o        (instr_ready_o),
        .decoded_instr_o      (decoded_instr_o),
        .orig_instr_o         (orig_instr_o),
        .is_ctrl_flow_o       (is_ctrl_flow_o),
        .decoded_instr_valid_o(decoded_instr_valid_o),
        .decoded_instr_ack_i  (decoded_instr_ack_i),
        .resolve_branch_i     (resolve_branch_i),
        .count_o              (count_o),
        .cf_pending_o         (cf_pending_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic cf, input logic ack);
        instr_valid_i       = v;
        instr_i             = d;
        orig_instr_i        = {24'hC0FFEE, d};
        is_ctrl_flow_i      = cf;
        decoded_instr_ack_i = ack;
        #1;
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; resolve_branch_i = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick(); tick();
        chk("rst_valid", 32'(decoded_instr_valid_o), 32'd0);
        chk("rst_ready", 32'(instr_ready_o), 32'd1);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_cf", 32'(cf_pending_o), 32'd0);
        chk("rst_data", 32'(decoded_instr_o), 32'd0);
        chk("rst_orig", orig_instr_o, 32'd0);
        rst_ni = 1'b1;

        // A,B,C pushed back-to-back with ack held high
        drive(1'b1, 8'h11, 1'b0, 1'b1);
        chk("a_valid_before", 32'(decoded_instr_valid_o), 32'd0);
        tick(); drive(1'b1, 8'h12, 1'b0, 1'b1);
        chk("a_valid", 32'(decoded_instr_valid_o), 32'd1);
        chk("a_data", 32'(decoded_instr_o), 32'h11);
        chk("a_orig", orig_instr_o, 32'hC0FFEE11);
        tick(); drive(1'b1, 8'h13, 1'b0, 1'b1);
        chk("b_data", 32'(decoded_instr_o), 32'h12);
        chk("b_count", 32'(count_o), 32'd1);
        tick(); drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("c_data", 32'(decoded_instr_o), 32'h13);
        chk("c_valid", 32'(decoded_instr_valid_o), 32'd1);
        tick(); drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("abc_count0", 32'(count_o), 32'd0);
        chk("abc_valid0", 32'(decoded_instr_valid_o), 32'd0);

        // Fill to DEPTH, fifth push refused, then full+ack and push+ack
        drive(1'b1, 8'h21, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h22, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h23, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h24, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h25, 1'b0, 1'b1);
        chk("full_ready", 32'(instr_ready_o), 32'd0);
        chk("full_count", 32'(count_o), 32'd4);
        chk("full_head", 32'(decoded_instr_o), 32'h21);
        tick();
        chk("full_pop_count", 32'(count_o), 32'd3);
        chk("full_pop_ready", 32'(instr_ready_o), 32'd1);
        chk("full_pop_head", 32'(decoded_instr_o), 32'h22);
        tick(); drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("pushpop_count", 32'(count_o), 32'd3);
        chk("drain0", 32'(decoded_instr_o), 32'h23);
        tick();
        chk("drain1", 32'(decoded_instr_o), 32'h24);
        tick();
        chk("drain2", 32'(decoded_instr_o), 32'h25);
        tick(); drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("drain_count", 32'(count_o), 32'd0);

        // Two branches with MAX_CF_PENDING=1
        drive(1'b1, 8'h31, 1'b1, 1'b0); tick();
        drive(1'b1, 8'h32, 1'b1, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("j1_valid", 32'(decoded_instr_valid_o), 32'd1);
        chk("j1_cf", 32'(is_ctrl_flow_o), 32'd1);
        chk("j1_data", 32'(decoded_instr_o), 32'h31);
        tick();
        chk("j2_pending", 32'(cf_pending_o), 32'd1);
        chk("j2_blocked", 32'(decoded_instr_valid_o), 32'd0);
        chk("j2_head", 32'(decoded_instr_o), 32'h32);
        tick();
        chk("j2_ack_ignored", 32'(count_o), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        resolve_branch_i = 1'b1;
        tick();
        resolve_branch_i = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("j2_unblocked", 32'(decoded_instr_valid_o), 32'd1);
        chk("resolve_pending0", 32'(cf_pending_o), 32'd0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ack_resolve_pending", 32'(cf_pending_o), 32'd1);
        chk("j2_popped", 32'(count_o), 32'd0);
        tick(); tick();
        resolve_branch_i = 1'b0;
        chk("resolve_saturate", 32'(cf_pending_o), 32'd0);

        // Flush with three entries, pending branch and a concurrent push
        drive(1'b1, 8'h41, 1'b1, 1'b0); tick();
        drive(1'b1, 8'h51, 1'b0, 1'b1); tick();
        drive(1'b1, 8'h52, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h53, 1'b0, 1'b0); tick();
        chk("pre_flush_count", 32'(count_o), 32'd3);
        chk("pre_flush_pending", 32'(cf_pending_o), 32'd1);
        flush_i = 1'b1;
        drive(1'b1, 8'h54, 1'b0, 1'b1);
        chk("flush_valid", 32'(decoded_instr_valid_o), 32'd0);
        tick();
        flush_i = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("post_flush_count", 32'(count_o), 32'd0);
        chk("post_flush_pending", 32'(cf_pending_o), 32'd0);
        chk("post_flush_valid", 32'(decoded_instr_valid_o), 32'd0);
        drive(1'b1, 8'h55, 1'b0, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("post_flush_head", 32'(decoded_instr_o), 32'h55);
        tick();

        // Ten push/pop pairs across pointer wrap
        for (int k = 0; k <= 10; k++) begin
            drive(k < 10, 8'(8'h60 + k), 1'b0, k > 0);
            if (k > 0) begin
                chk("wrap_data", 32'(decoded_instr_o), 32'(8'h60 + k - 1));
                chk("wrap_orig", orig_instr_o, {24'hC0FFEE, 8'(8'h60 + k - 1)});
            end
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("wrap_count", 32'(count_o), 32'd0);

        // Asynchronous reset mid-operation
        drive(1'b1, 8'h71, 1'b0, 1'b0); tick(); tick();
        chk("pre_rst_count", 32'(count_o), 32'd2);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count_o), 32'd0);
        chk("mid_rst_valid", 32'(decoded_instr_valid_o), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        rst_ni = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
